// File: rtl/spi_master.sv
// -----------------------------------------------------------------------------
// spi_master
//   SPI mode-0 bus master (CPOL=0, CPHA=0, MSB first). A one-cycle start
//   request launches a WIDTH-bit full-duplex transfer; SCLK is generated by
//   dividing clk, with CLK_DIV clk cycles per SCLK half-period. Each transfer is
//   framed as LEAD (csn low, sclk low), SHIFT (WIDTH SCLK periods), TRAIL
//   (sclk low, csn still low) and GAP (csn high, still busy).
//
// Parameters
//   WIDTH   : bits per transfer (>= 2)
//   CLK_DIV : SCLK half-period in clk cycles (>= 1)
//
// Ports
//   clk          : system clock, rising edge
//   rst          : asynchronous active-high reset
//   start        : transfer request, sampled only while busy=0
//   send         : word to transmit, latched when start is accepted
//   busy         : high from the cycle after acceptance to the end of GAP
//   recv         : last received word, updated at transfer completion
//   output_valid : one-cycle pulse when recv is updated
//   sclk         : SPI clock, idles low
//   csn          : active-low chip select
//   mosi         : serial data out
//   miso         : serial data in, synchronous to the generated SCLK
// -----------------------------------------------------------------------------
module spi_master #(
  parameter int WIDTH   = 8,
  parameter int CLK_DIV = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] send,
  output logic             busy,
  output logic [WIDTH-1:0] recv,
  output logic             output_valid,
  output logic             sclk,
  output logic             csn,
  output logic             mosi,
  input  logic             miso
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEAD,
    S_SHIFT,
    S_TRAIL,
    S_GAP
  } state_e;

  // One extra count of headroom keeps the divider at least 1 bit wide when
  // CLK_DIV=1, and lets the bit counter reach WIDTH itself.
  localparam int DIV_W = $clog2(CLK_DIV + 1);
  localparam int BIT_W = $clog2(WIDTH + 1);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WIDTH);

  state_e           state_q;
  logic [DIV_W-1:0] div_q;
  logic [BIT_W-1:0] bit_q;
  logic [WIDTH-1:0] tx_q;
  logic [WIDTH-1:0] rx_q;
  logic [WIDTH-1:0] recv_q;
  logic             busy_q;
  logic             valid_q;
  logic             sclk_q;
  logic             csn_q;
  logic             mosi_q;

  logic div_done;
  assign div_done = (div_q == DIV_LAST);

  // NOTE: every register here, including the data shift registers and recv,
  // is reset: an aborted transfer must leave recv cleared and nothing stale.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      tx_q    <= '0;
      rx_q    <= '0;
      recv_q  <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      sclk_q  <= 1'b0;
      csn_q   <= 1'b1;
      mosi_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every branch below sees
      // the pre-edge values of all state (e.g. tx_q when picking the next bit).
      valid_q <= 1'b0;

      case (state_q)
        S_IDLE: begin
          div_q <= '0;
          if (start) begin
            state_q <= S_LEAD;
            tx_q    <= send;
            mosi_q  <= send[WIDTH-1];
            csn_q   <= 1'b0;
            busy_q  <= 1'b1;
            bit_q   <= '0;
          end
        end

        // The edge that leaves LEAD is also the first SCLK rising edge.
        S_LEAD: begin
          if (div_done) begin
            div_q   <= '0;
            state_q <= S_SHIFT;
            sclk_q  <= 1'b1;
            rx_q    <= {rx_q[WIDTH-2:0], miso};
            bit_q   <= BIT_W'(1);
          end else begin
            div_q <= div_q + DIV_W'(1);
          end
        end

        S_SHIFT: begin
          if (div_done) begin
            div_q <= '0;
            if (!sclk_q) begin
              // Rising edge: capture miso.
              sclk_q <= 1'b1;
              rx_q   <= {rx_q[WIDTH-2:0], miso};
              bit_q  <= bit_q + BIT_W'(1);
            end else begin
              // Falling edge: advance mosi, or park it after the last bit.
              sclk_q <= 1'b0;
              if (bit_q == BIT_LAST) begin
                mosi_q  <= 1'b0;
                state_q <= S_TRAIL;
              end else begin
                mosi_q <= tx_q[WIDTH-2];
                tx_q   <= {tx_q[WIDTH-2:0], 1'b0};
              end
            end
          end else begin
            div_q <= div_q + DIV_W'(1);
          end
        end

        S_TRAIL: begin
          if (div_done) begin
            div_q   <= '0;
            state_q <= S_GAP;
            csn_q   <= 1'b1;
            recv_q  <= rx_q;
            valid_q <= 1'b1;
          end else begin
            div_q <= div_q + DIV_W'(1);
          end
        end

        // busy stays high here to guarantee a minimum csn-high time.
        S_GAP: begin
          if (div_done) begin
            div_q   <= '0;
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else begin
            div_q <= div_q + DIV_W'(1);
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy         = busy_q;
  assign recv         = recv_q;
  assign output_valid = valid_q;
  assign sclk         = sclk_q;
  assign csn          = csn_q;
  assign mosi         = mosi_q;

endmodule

// File: tb/tb_spi_master.sv
// -----------------------------------------------------------------------------
// tb_spi_master
//   Self-checking bench for spi_master. Two instances share one clock:
//   dut_a (WIDTH=8, CLK_DIV=2) and dut_b (WIDTH=16, CLK_DIV=1). Expected
//   waveforms are computed per cycle from the transfer timing rules
//   (offsets from the acceptance cycle T), and expected received words from
//   the data the bench puts on miso.
// -----------------------------------------------------------------------------
module tb_spi_master;

  localparam int WA = 8;
  localparam int DA = 2;
  localparam int WB = 16;
  localparam int DB = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // dut_a signals
  logic          a_rst, a_start, a_busy, a_ov, a_sclk, a_csn, a_mosi, a_miso;
  logic [WA-1:0] a_send, a_recv;
  logic          a_loop, a_miso_drv;
  assign a_miso = a_loop ? a_mosi : a_miso_drv;

  // dut_b signals
  logic          b_rst, b_start, b_busy, b_ov, b_sclk, b_csn, b_mosi, b_miso;
  logic [WB-1:0] b_send, b_recv;
  logic          b_loop, b_miso_drv;
  assign b_miso = b_loop ? b_mosi : b_miso_drv;

  spi_master #(.WIDTH(WA), .CLK_DIV(DA)) dut_a (
    .clk(clk), .rst(a_rst), .start(a_start), .send(a_send), .busy(a_busy),
    .recv(a_recv), .output_valid(a_ov), .sclk(a_sclk), .csn(a_csn),
    .mosi(a_mosi), .miso(a_miso)
  );

  spi_master #(.WIDTH(WB), .CLK_DIV(DB)) dut_b (
    .clk(clk), .rst(b_rst), .start(b_start), .send(b_send), .busy(b_busy),
    .recv(b_recv), .output_valid(b_ov), .sclk(b_sclk), .csn(b_csn),
    .mosi(b_mosi), .miso(b_miso)
  );

  // Observed signals of the instance currently under test.
  int          sel = 0;
  logic        m_csn, m_sclk, m_mosi, m_busy, m_ov;
  logic [15:0] m_recv;
  always_comb begin
    m_csn  = a_csn;
    m_sclk = a_sclk;
    m_mosi = a_mosi;
    m_busy = a_busy;
    m_ov   = a_ov;
    m_recv = {8'h00, a_recv};
    if (sel == 1) begin
      m_csn  = b_csn;
      m_sclk = b_sclk;
      m_mosi = b_mosi;
      m_busy = b_busy;
      m_ov   = b_ov;
      m_recv = b_recv;
    end
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
  endtask

  // ---------------------------------------------------------------- drivers
  task automatic set_start(input int s, input logic v);
    if (s == 1) b_start = v; else a_start = v;
  endtask

  task automatic set_send(input int s, input logic [15:0] word);
    if (s == 1) b_send = word; else a_send = word[7:0];
  endtask

  task automatic set_loop(input int s, input logic v);
    if (s == 1) b_loop = v; else a_loop = v;
  endtask

  task automatic set_miso(input int s, input logic v);
    if (s == 1) b_miso_drv = v; else a_miso_drv = v;
  endtask

  // ------------------------------------------------------- reference model
  // c = cycles after the acceptance cycle T. Bit k is on the wire from the
  // falling edge before it (cycle 1+2kD) to its own falling edge.
  function automatic logic model_bit(input logic [15:0] word, input int w, input int d, input int c);
    int k;
    if (c < 1) return 1'b0;
    k = (c - 1) / (2 * d);
    if (k >= w) return 1'b0;
    return word[w-1-k];
  endfunction

  function automatic logic model_sclk(input int w, input int d, input int c);
    int q;
    if (c < 1) return 1'b0;
    q = (c - 1) / d;
    return (q % 2 == 1) && (q < 2 * w);
  endfunction

  function automatic logic model_csn(input int w, input int d, input int c);
    return !(c >= 1 && c < 1 + d * (2 * w + 1));
  endfunction

  function automatic logic model_busy(input int w, input int d, input int c);
    return (c >= 1 && c < 1 + d * (2 * w + 2));
  endfunction

  // ------------------------------------------------------ one full transfer
  // loop=1: miso tied to mosi, expect recv=word. loop=0: the bench drives
  // rx_word on miso bit by bit. poke=1: a second start with a different word
  // at T+10, which must be ignored.
  task automatic run_xfer(input int s, input logic [15:0] word, input logic loop,
                          input logic [15:0] rx_word, input logic poke);
    int w, d, t, c, last;
    int csn_fall, csn_rise, busy_fall, ov_n, ov_c, rises;
    int csn_err, sclk_err, mosi_err, busy_err;
    logic [15:0] mask, exp_word, ov_recv;
    logic prev_sclk, prev_csn, prev_busy;
    string id;

    w = (s == 1) ? WB : WA;
    d = (s == 1) ? DB : DA;
    sel = s;
    mask = 16'((32'h1 << w) - 1);
    word = word & mask;
    exp_word = (loop ? word : rx_word) & mask;
    id = $sformatf("%s_%0h", (s == 1) ? "b" : "a", word);
    set_loop(s, loop);
    csn_fall = -1; csn_rise = -1; busy_fall = -1; ov_n = 0; ov_c = -1;
    rises = 0; csn_err = 0; sclk_err = 0; mosi_err = 0; busy_err = 0;
    ov_recv = '0;

    @(negedge clk);
    set_send(s, word);
    set_start(s, 1'b1);
    t = cyc;
    prev_sclk = m_sclk;
    prev_csn  = m_csn;
    prev_busy = m_busy;
    last = 1 + d * (2 * w + 2) + 1;

    for (int i = 1; i <= last; i++) begin
      @(negedge clk);
      c = cyc - t;
      if (c == 1) begin
        set_start(s, 1'b0);
        set_send(s, 16'($urandom));
      end
      if (poke && c == 10) begin
        set_send(s, 16'h003C);
        set_start(s, 1'b1);
      end
      if (poke && c == 11) set_start(s, 1'b0);

      if (m_csn  !== model_csn(w, d, c))        csn_err++;
      if (m_sclk !== model_sclk(w, d, c))       sclk_err++;
      if (m_mosi !== model_bit(word, w, d, c))  mosi_err++;
      if (m_busy !== model_busy(w, d, c))       busy_err++;
      if (prev_csn && !m_csn && csn_fall < 0)   csn_fall = c;
      if (!prev_csn && m_csn && csn_rise < 0)   csn_rise = c;
      if (prev_busy && !m_busy && busy_fall < 0) busy_fall = c;
      if (!prev_sclk && m_sclk) rises++;
      if (m_ov) begin
        ov_n++;
        ov_c = c;
        ov_recv = m_recv;
      end
      prev_sclk = m_sclk;
      prev_csn  = m_csn;
      prev_busy = m_busy;
      if (!loop) set_miso(s, model_bit(rx_word, w, d, c));
    end

    check({id, "_csn_fall"},  csn_fall, 1);
    check({id, "_csn_rise"},  csn_rise, 1 + d * (2 * w + 1));
    check({id, "_busy_fall"}, busy_fall, 1 + d * (2 * w + 2));
    check({id, "_sclk_rises"}, rises, w);
    check({id, "_ov_count"},  ov_n, 1);
    check({id, "_ov_cycle"},  ov_c, 1 + d * (2 * w + 1));
    check({id, "_ov_recv"},   ov_recv, exp_word);
    check({id, "_recv_hold"}, m_recv, exp_word);
    check({id, "_csn_wave"},  csn_err, 0);
    check({id, "_sclk_wave"}, sclk_err, 0);
    check({id, "_mosi_wave"}, mosi_err, 0);
    check({id, "_busy_wave"}, busy_err, 0);
  endtask

  // ------------------------------------------------------------ main flow
  initial begin
    int t, c, nf, nr, nv, ov_seen;
    int fall_c[4];
    int rise_c[4];
    int ov_c[4];
    logic [15:0] ov_v[4];
    logic prev_csn;

    a_rst = 1'b1; a_start = 1'b0; a_send = '0; a_loop = 1'b0; a_miso_drv = 1'b0;
    b_rst = 1'b1; b_start = 1'b0; b_send = '0; b_loop = 1'b0; b_miso_drv = 1'b0;

    repeat (3) @(negedge clk);
    check("rst_csn",  a_csn, 1'b1);
    check("rst_sclk", a_sclk, 1'b0);
    check("rst_mosi", a_mosi, 1'b0);
    check("rst_busy", a_busy, 1'b0);
    check("rst_ov",   a_ov, 1'b0);
    check("rst_recv", a_recv, 8'h00);
    check("rst_b_csn_busy", {b_csn, b_busy}, 2'b10);
    a_rst = 1'b0;
    b_rst = 1'b0;
    repeat (2) @(negedge clk);

    // Loopback, then fixed miso all-ones / all-zeros with send=0.
    run_xfer(0, 16'h00A5, 1'b1, 16'h0000, 1'b0);
    run_xfer(0, 16'h0000, 1'b0, 16'h00FF, 1'b0);
    run_xfer(0, 16'h0000, 1'b0, 16'h0000, 1'b0);

    // Start while busy must be ignored.
    run_xfer(0, 16'h00C3, 1'b1, 16'h0000, 1'b1);

    // Back-to-back with start held high.
    sel = 0;
    set_loop(0, 1'b1);
    nf = 0; nr = 0; nv = 0;
    @(negedge clk);
    a_send = 8'h96;
    a_start = 1'b1;
    t = cyc;
    prev_csn = a_csn;
    for (int i = 1; i <= 80; i++) begin
      @(negedge clk);
      c = cyc - t;
      if (c == 1)  a_send = 8'h69;
      if (c == 40) a_start = 1'b0;
      if (prev_csn && !a_csn && nf < 4) begin fall_c[nf] = c; nf++; end
      if (!prev_csn && a_csn && nr < 4) begin rise_c[nr] = c; nr++; end
      if (a_ov && nv < 4) begin ov_c[nv] = c; ov_v[nv] = {8'h00, a_recv}; nv++; end
      prev_csn = a_csn;
    end
    check("b2b_n_fall", nf, 2);
    check("b2b_n_ov",   nv, 2);
    if (nf == 2 && nr == 2 && nv == 2) begin
      check("b2b_fall0", fall_c[0], 1);
      check("b2b_rise0", rise_c[0], 1 + DA * (2 * WA + 1));
      check("b2b_fall1", fall_c[1], 1 + DA * (2 * WA + 2) + 1);
      check("b2b_csn_high", fall_c[1] - rise_c[0], DA + 1);
      check("b2b_rise1", rise_c[1], fall_c[1] + DA * (2 * WA + 1));
      check("b2b_ov0",   {ov_c[0], ov_v[0]}, {32'(1 + DA * (2 * WA + 1)), 16'h0096});
      check("b2b_ov1",   {ov_c[1], ov_v[1]}, {32'(fall_c[1] + DA * (2 * WA + 1)), 16'h0069});
    end else begin
      check("b2b_n_rise", nr, 2);
    end
    check("b2b_idle_busy", a_busy, 1'b0);

    // Reset mid-transfer at T+12 (sclk high at that point).
    set_loop(0, 1'b1);
    ov_seen = 0;
    @(negedge clk);
    a_send = 8'hF0;
    a_start = 1'b1;
    t = cyc;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (cyc - t == 1) a_start = 1'b0;
      if (a_ov) ov_seen++;
    end
    check("mid_sclk_before", a_sclk, 1'b1);
    #1 a_rst = 1'b1;
    #1;
    check("mid_csn",  a_csn, 1'b1);
    check("mid_sclk", a_sclk, 1'b0);
    check("mid_mosi", a_mosi, 1'b0);
    check("mid_busy", a_busy, 1'b0);
    check("mid_recv", a_recv, 8'h00);
    @(negedge clk);
    a_rst = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (a_ov) ov_seen++;
    end
    check("mid_no_ov", ov_seen, 0);
    check("mid_idle_csn", a_csn, 1'b1);
    run_xfer(0, 16'h005E, 1'b1, 16'h0000, 1'b0);

    // Randomised transfers on dut_a.
    for (int i = 0; i < 6; i++)
      run_xfer(0, 16'($urandom), 1'($urandom_range(0, 1)), 16'($urandom), 1'b0);

    // Minimum divider on dut_b.
    run_xfer(1, 16'h8001, 1'b1, 16'h0000, 1'b0);
    for (int i = 0; i < 3; i++)
      run_xfer(1, 16'($urandom), 1'($urandom_range(0, 1)), 16'($urandom), 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/spi_master.md
# spi_master

SPI bus master (mode 0: CPOL=0, CPHA=0, MSB first) that drives SCLK, chip select and MOSI toward an external SPI slave and captures MISO. It is the initiator counterpart to the FPGA's `spi_slave`, and lets the FPGA itself control SPI peripherals such as DAC or codec configuration ports. It runs in the system clock domain and generates SCLK by integer division. A one-cycle start request launches a full WIDTH-bit transfer; completion is signalled by a one-cycle `output_valid` pulse.

## Interface
- `WIDTH`, 8: bits per transfer; legal range ≥ 2.
- `CLK_DIV`, 2: SCLK half-period in `clk` cycles; legal range ≥ 1.

- `clk`  input  1  system clock; all logic is on its rising edge.
- `rst`  input  1  asynchronous, active-high reset.
- `start`  input  1  transfer request; sampled only while `busy`=0.
- `send`  input  WIDTH  word to transmit; latched on the cycle `start` is accepted.
- `busy`  output  1  high from the cycle after acceptance until the transfer sequence ends.
- `recv`  output  WIDTH  last received word; updated only at transfer completion.
- `output_valid`  output  1  one-cycle pulse when `recv` is updated.
- `sclk`  output  1  SPI clock; idles low.
- `csn`  output  1  active-low chip select.
- `mosi`  output  1  serial data out.
- `miso`  input  1  serial data in; treated as synchronous to the SCLK the block generates, so no synchronizer is used.

## Operation
- Reset values: `sclk`=0, `csn`=1, `mosi`=0, `busy`=0, `output_valid`=0, `recv`=0. The FSM resets to IDLE and all counters reset to 0.
- FSM states:
  - IDLE → LEAD on `start`=1.
  - LEAD → SHIFT after CLK_DIV cycles.
  - SHIFT → TRAIL after WIDTH full SCLK periods.
  - TRAIL → GAP after CLK_DIV cycles.
  - GAP → IDLE after CLK_DIV cycles.
- Accept: on the cycle `start`=1 in IDLE, latch `send` into the TX shift register.
- LEAD: `csn`=0, `mosi`=`send[WIDTH-1]`, `sclk`=0.
- SHIFT: `sclk` toggles every CLK_DIV cycles, starting with a rising edge.
  - On the `clk` edge that drives `sclk` 0→1, shift `miso` into the LSB of the RX shift register.
  - On the `clk` edge that drives `sclk` 1→0, present the next TX bit on `mosi`. After the WIDTH-th falling edge, drive `mosi`=0.
  - A bit counter (width ≥ clog2(WIDTH+1)) counts rising edges.
  - A divider counter counts 0..CLK_DIV-1 and wraps.
- TRAIL: `csn` stays 0 and `sclk` stays 0 for CLK_DIV cycles.
- Entering GAP (same edge):
  - `csn`→1.
  - `recv` ← RX shift register.
  - `output_valid`=1 for exactly that one cycle.
- GAP: `busy` stays 1 to enforce a minimum `csn`-high time of CLK_DIV cycles.
- `start` while `busy`=1 is ignored; it is not queued.
- Changes to `send` after acceptance have no effect on the current transfer.
- `start` held high continuously produces back-to-back transfers, each separated by the GAP time plus one IDLE cycle.
- Reset asserted mid-transfer aborts immediately:
  - Outputs return to reset values asynchronously.
  - No `output_valid` is generated.
  - `recv` is cleared to 0.

## Timing
- Let T be the acceptance cycle and D = CLK_DIV, W = WIDTH.
- T+1: `csn`=0, `busy`=1, `mosi`=MSB.
- Rising edge of bit k (k = 0..W-1) at T+1+D·(1+2k).
- Falling edge of bit k at T+1+D·(2+2k).
- T+1+D·(2W+1): `csn`=1, `output_valid`=1, new `recv` visible.
- T+1+D·(2W+2): `busy`=0; a new `start` is acceptable in this cycle.
- SCLK frequency = f_clk / (2·D). Duty cycle is exactly 50%.
- MOSI is stable ≥ D cycles before each rising SCLK edge. MISO is sampled at the rising edge and must be valid by then (mode 0).

## Test plan
- **Loopback**, `mosi` tied to `miso`, W=8, D=2, `send`=8'hA5, `start` at T:
  - `csn` falls at T+1 and rises at T+35.
  - Exactly 8 SCLK rising edges.
  - `output_valid` pulses only at T+35 with `recv`=8'hA5.
  - `busy` falls at T+37.
- **Fixed MISO**, `miso`=1, `send`=8'h00:
  - `mosi` is 0 throughout.
  - `recv`=8'hFF.
  - A second transfer with `miso`=0 gives `recv`=8'h00.
- **Start while busy**: second `start` pulse at T+10 with `send`=8'h3C:
  - Ignored.
  - Exactly one `output_valid` pulse.
  - `recv` equals the first word.
- **Back-to-back**, `start` held high:
  - Second acceptance at T+37 and second `csn` fall at T+38.
  - `csn` high for exactly 3 cycles between transfers.
- **Reset mid-transfer**, `rst` asserted at T+12:
  - `csn`=1, `sclk`=0, `mosi`=0, `busy`=0 immediately.
  - No `output_valid`.
  - `recv`=0.
  - A subsequent transfer completes normally.
- **Minimum divider**, D=1, W=16, `send`=16'h8001, loopback:
  - SCLK toggles every cycle.
  - `recv`=16'h8001 at T+34.
  - `busy` falls at T+35.
